// File: rtl/alu_pkg.sv
// ---------------------------------------------------------------------------
// alu_pkg
// Shared definitions for the matrix ALU coprocessor slice:
//   - estado_t : FSM state encoding used by alu_matrizes
//   - op_t     : sel_operacao codes (soma, subtracao, oposto, copia A)
//   - MATRIX_DIM_DEF / DATA_W_DEF : default matrix size and element width
// ---------------------------------------------------------------------------
package alu_pkg;

    localparam int MATRIX_DIM_DEF = 5;
    localparam int DATA_W_DEF     = 8;

    typedef enum logic [2:0] {
        OCIOSO   = 3'd0,
        LER      = 3'd1,
        CALC     = 3'd2,
        ESCREVER = 3'd3,
        FIM      = 3'd4
    } estado_t;

    typedef enum logic [1:0] {
        OP_SOMA      = 2'b00,
        OP_SUBTRACAO = 2'b01,
        OP_OPOSTO    = 2'b10,
        OP_COPIA     = 2'b11
    } op_t;

endpackage

// File: rtl/alu_elemento.sv
// ---------------------------------------------------------------------------
// alu_elemento
// Purely combinational per-element operation for the matrix ALU.
// Optional feature macro: ALU_SATURACAO_EN (saturate instead of wrap).
// Ports:
//   op        in  2 bits       operation code (alu_pkg::op_t encoding)
//   a, b      in  DATA_W bits  signed operands (elements of A and B)
//   resultado out DATA_W bits  result element for matrix C
//   overflow  out 1 bit        exact result does not fit in DATA_W signed
// ---------------------------------------------------------------------------
module alu_elemento
    import alu_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic [1:0]        op,
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    output logic [DATA_W-1:0] resultado,
    output logic              overflow
);

    logic signed [DATA_W:0] a_ext;
    logic signed [DATA_W:0] b_ext;
    logic signed [DATA_W:0] exato;

    // One extra bit of headroom holds the exact result of every operation,
    // including -(-2^(DATA_W-1)); overflow is then a disagreement between
    // the two top bits.
    always_comb begin
        a_ext = {a[DATA_W-1], a};
        b_ext = {b[DATA_W-1], b};
        exato = a_ext;
        case (op_t'(op))
            OP_SOMA:      exato = a_ext + b_ext;
            OP_SUBTRACAO: exato = a_ext - b_ext;
            OP_OPOSTO:    exato = -a_ext;
            OP_COPIA:     exato = a_ext;
            default:      exato = a_ext;
        endcase
    end

    assign overflow = exato[DATA_W] ^ exato[DATA_W-1];

    // The sign of the exact result picks which limit to clamp to.
    always_comb begin
        resultado = exato[DATA_W-1:0];
`ifdef ALU_SATURACAO_EN
        if (overflow) begin
            resultado = exato[DATA_W] ? {1'b1, {(DATA_W-1){1'b0}}}
                                      : {1'b0, {(DATA_W-1){1'b1}}};
        end
`endif
    end

endmodule

// File: rtl/alu_matrizes.sv
// ---------------------------------------------------------------------------
// alu_matrizes
// Element-serial matrix ALU: C = op(A, B) over MATRIX_DIM x MATRIX_DIM
// signed DATA_W-bit elements, three cycles per element (read, compute,
// write). Optional feature macro: ALU_SATURACAO_EN (see alu_elemento).
// Ports:
//   clk            in   system clock, rising edge
//   reset_n        in   asynchronous active-low reset
//   start_calc     in   one-cycle start pulse (ignored while ocupado)
//   sel_operacao   in   2 bits: 00 soma, 01 subtracao, 10 oposto, 11 copia A
//   dado_a, dado_b in   DATA_W bits, elements read from memory (1-cycle latency)
//   endereco       out  element index for both read and write
//   re_mem, we_mem out  memory read / write strobes (never both high)
//   dado_c         out  DATA_W bits, result element for matrix C
//   ocupado        out  busy level (high outside OCIOSO)
//   done           out  one-cycle completion pulse
//   overflow       out  sticky overflow, cleared on the next accepted start
// ---------------------------------------------------------------------------
module alu_matrizes
    import alu_pkg::*;
#(
    parameter  int MATRIX_DIM = MATRIX_DIM_DEF,
    parameter  int DATA_W     = DATA_W_DEF,
    localparam int N_ELEM     = MATRIX_DIM * MATRIX_DIM,
    localparam int ADDR_W     = (N_ELEM > 1) ? $clog2(N_ELEM) : 1
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              start_calc,
    input  logic [1:0]        sel_operacao,
    input  logic [DATA_W-1:0] dado_a,
    input  logic [DATA_W-1:0] dado_b,
    output logic [ADDR_W-1:0] endereco,
    output logic              re_mem,
    output logic              we_mem,
    output logic [DATA_W-1:0] dado_c,
    output logic              ocupado,
    output logic              done,
    output logic              overflow
);

    localparam logic [ADDR_W-1:0] ULTIMO_END = ADDR_W'(N_ELEM - 1);

    estado_t           estado;
    op_t               op_reg;
    logic [DATA_W-1:0] res_elem;
    logic              ovf_elem;

    alu_elemento #(
        .DATA_W (DATA_W)
    ) u_elemento (
        .op        (op_reg),
        .a         (dado_a),
        .b         (dado_b),
        .resultado (res_elem),
        .overflow  (ovf_elem)
    );

    // All strobes are registered on the transition into the state that owns
    // them, so re_mem is high exactly during LER, we_mem during ESCREVER and
    // done during FIM. Memory data requested in LER is valid during CALC and
    // captured at the end of CALC. Reset drops everything at once, so an
    // interrupted operation never produces another write.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            estado   <= OCIOSO;
            op_reg   <= OP_SOMA;
            endereco <= '0;
            re_mem   <= 1'b0;
            we_mem   <= 1'b0;
            dado_c   <= '0;
            ocupado  <= 1'b0;
            done     <= 1'b0;
            overflow <= 1'b0;
        end else begin
            case (estado)
                OCIOSO: begin
                    done <= 1'b0;
                    if (start_calc) begin
                        op_reg   <= op_t'(sel_operacao);
                        endereco <= '0;
                        overflow <= 1'b0;
                        re_mem   <= 1'b1;
                        ocupado  <= 1'b1;
                        estado   <= LER;
                    end
                end
                LER: begin
                    re_mem <= 1'b0;
                    estado <= CALC;
                end
                CALC: begin
                    dado_c <= res_elem;
                    if (ovf_elem) begin
                        overflow <= 1'b1;
                    end
                    we_mem <= 1'b1;
                    estado <= ESCREVER;
                end
                ESCREVER: begin
                    we_mem <= 1'b0;
                    if (endereco == ULTIMO_END) begin
                        done   <= 1'b1;
                        estado <= FIM;
                    end else begin
                        endereco <= endereco + ADDR_W'(1);
                        re_mem   <= 1'b1;
                        estado   <= LER;
                    end
                end
                FIM: begin
                    done    <= 1'b0;
                    ocupado <= 1'b0;
                    estado  <= OCIOSO;
                end
                default: begin
                    re_mem  <= 1'b0;
                    we_mem  <= 1'b0;
                    done    <= 1'b0;
                    ocupado <= 1'b0;
                    estado  <= OCIOSO;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_alu_matrizes.sv
// ---------------------------------------------------------------------------
// tb_alu_matrizes
// Directed self-checking bench for alu_matrizes (default 5x5, 8-bit).
// Follows ALU_SATURACAO_EN to pick the expected overflow results.
// ---------------------------------------------------------------------------
module tb_alu_matrizes;

    logic              clk = 1'b0;
    logic              reset_n;
    logic              start_calc;
    logic [1:0]        sel_operacao;
    logic signed [7:0] dado_a;
    logic signed [7:0] dado_b;
    logic [4:0]        endereco;
    logic              re_mem;
    logic              we_mem;
    logic signed [7:0] dado_c;
    logic              ocupado;
    logic              done;
    logic              overflow;

    logic signed [7:0] mem_a [25];
    logic signed [7:0] mem_b [25];
    logic signed [7:0] exp_c [25];
    logic [4:0]        wr_addr [64];
    logic signed [7:0] wr_data [64];
    int                wr_n;
    int                done_cnt;
    int                excl_err;
    logic              rd_pend;
    logic [4:0]        rd_addr;
    int                n_cmp;
    int                n_fail;
    int                done_at;

    alu_matrizes #(
        .MATRIX_DIM (5),
        .DATA_W     (8)
    ) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .start_calc   (start_calc),
        .sel_operacao (sel_operacao),
        .dado_a       (dado_a),
        .dado_b       (dado_b),
        .endereco     (endereco),
        .re_mem       (re_mem),
        .we_mem       (we_mem),
        .dado_c       (dado_c),
        .ocupado      (ocupado),
        .done         (done),
        .overflow     (overflow)
    );

    always #5 clk = ~clk;

    // Memory side, observed away from the rising edge: log writes, count
    // done pulses and strobe collisions, and remember read requests.
    always @(negedge clk) begin
        rd_pend = re_mem;
        rd_addr = endereco;
        if (we_mem && wr_n < 64) begin
            wr_addr[wr_n] = endereco;
            wr_data[wr_n] = dado_c;
            wr_n++;
        end
        if (done) done_cnt++;
        if (re_mem && we_mem) excl_err++;
    end

    // Synchronous RAM with one cycle of read latency.
    always @(posedge clk) begin
        if (rd_pend) begin
            dado_a <= mem_a[rd_addr];
            dado_b <= mem_b[rd_addr];
        end
    end

    task automatic clear_log();
        wr_n     = 0;
        done_cnt = 0;
        excl_err = 0;
    endtask

    task automatic fill_mem(input int va, input int vb);
        for (int i = 0; i < 25; i++) begin
            mem_a[i] = 8'(va);
            mem_b[i] = 8'(vb);
        end
    endtask

    // Pulses start and counts cycles until done (done_at=0 on timeout).
    // glitch_k re-pulses start with sel=01 at that cycle; reset_k asserts
    // reset at that cycle and returns immediately.
    task automatic run_op(input logic [1:0] sel, input int glitch_k,
                          input int reset_k, output int d_at);
        @(negedge clk);
        clear_log();
        sel_operacao = sel;
        start_calc   = 1'b1;
        d_at         = 0;
        for (int k = 1; k <= 200; k++) begin
            @(negedge clk);
            if (k == 1) start_calc = 1'b0;
            if (k == glitch_k) begin
                start_calc   = 1'b1;
                sel_operacao = 2'b01;
            end
            if (k == glitch_k + 1) start_calc = 1'b0;
            if (k == reset_k) begin
                reset_n = 1'b0;
                break;
            end
            if (done) begin
                d_at = k;
                break;
            end
        end
        #1;
    endtask

    task automatic test_reset();
        reset_n      = 1'b0;
        start_calc   = 1'b0;
        sel_operacao = 2'b00;
        dado_a       = '0;
        dado_b       = '0;
        rd_pend      = 1'b0;
        clear_log();
        repeat (3) @(negedge clk);
        n_cmp++;
        if ({endereco, re_mem, we_mem, dado_c, ocupado, done, overflow} !== 18'd0) begin
            n_fail++;
            $display("[TB] FAIL reset_outputs: got %b, want all zero",
                     {endereco, re_mem, we_mem, dado_c, ocupado, done, overflow});
        end
        reset_n = 1'b1;
        repeat (2) @(negedge clk);
        n_cmp++;
        if (ocupado !== 1'b0 || re_mem !== 1'b0) begin
            n_fail++;
            $display("[TB] FAIL idle_after_reset: ocupado=%b re_mem=%b, want 0 0", ocupado, re_mem);
        end
    endtask

    task automatic test_soma();
        fill_mem(10, 20);
        run_op(2'b00, 0, 0, done_at);
        n_cmp++;
        if (done_at !== 76) begin
            n_fail++;
            $display("[TB] FAIL soma_latency: done at t+%0d, want t+76", done_at);
        end
        n_cmp++;
        if (wr_n !== 25) begin
            n_fail++;
            $display("[TB] FAIL soma_write_count: %0d writes, want 25", wr_n);
        end
        for (int i = 0; i < 25; i++) begin
            n_cmp++;
            if (wr_addr[i] !== 5'(i) || wr_data[i] !== 8'sd30) begin
                n_fail++;
                $display("[TB] FAIL soma_write[%0d]: addr=%0d data=%0d, want addr=%0d data=30",
                         i, wr_addr[i], wr_data[i], i);
            end
        end
        n_cmp++;
        if (overflow !== 1'b0 || ocupado !== 1'b1) begin
            n_fail++;
            $display("[TB] FAIL soma_flags: overflow=%b ocupado=%b, want 0 1", overflow, ocupado);
        end
        @(negedge clk);
        n_cmp++;
        if (done !== 1'b0 || ocupado !== 1'b0 || done_cnt !== 1) begin
            n_fail++;
            $display("[TB] FAIL soma_done_pulse: done=%b ocupado=%b pulses=%0d, want 0 0 1",
                     done, ocupado, done_cnt);
        end
        n_cmp++;
        if (excl_err !== 0) begin
            n_fail++;
            $display("[TB] FAIL soma_strobe_exclusive: %0d collisions, want 0", excl_err);
        end
    endtask

    task automatic test_sub_overflow();
        fill_mem(10, 20);
        mem_a[0] = -8'sd128;
        mem_b[0] = 8'sd1;
`ifdef ALU_SATURACAO_EN
        exp_c[0] = -8'sd128;
`else
        exp_c[0] = 8'sd127;
`endif
        run_op(2'b01, 0, 0, done_at);
        n_cmp++;
        if (wr_data[0] !== exp_c[0] || wr_data[1] !== -8'sd10) begin
            n_fail++;
            $display("[TB] FAIL sub_results: C[0]=%0d C[1]=%0d, want %0d -10",
                     wr_data[0], wr_data[1], exp_c[0]);
        end
        n_cmp++;
        if (overflow !== 1'b1 || done_at !== 76) begin
            n_fail++;
            $display("[TB] FAIL sub_overflow: overflow=%b done at t+%0d, want 1 76", overflow, done_at);
        end
    endtask

    task automatic test_oposto();
        for (int i = 0; i < 25; i++) begin
            mem_a[i] = 8'(i);
            mem_b[i] = 8'sd7;
            exp_c[i] = 8'(-i);
        end
        mem_a[3] = -8'sd128;
        mem_a[4] = 8'sd5;
`ifdef ALU_SATURACAO_EN
        exp_c[3] = 8'sd127;
`else
        exp_c[3] = -8'sd128;
`endif
        exp_c[4] = -8'sd5;
        run_op(2'b10, 0, 0, done_at);
        for (int i = 0; i < 25; i++) begin
            n_cmp++;
            if (wr_addr[i] !== 5'(i) || wr_data[i] !== exp_c[i]) begin
                n_fail++;
                $display("[TB] FAIL oposto_write[%0d]: addr=%0d data=%0d, want addr=%0d data=%0d",
                         i, wr_addr[i], wr_data[i], i, exp_c[i]);
            end
        end
        n_cmp++;
        if (overflow !== 1'b1) begin
            n_fail++;
            $display("[TB] FAIL oposto_overflow: got %b, want 1", overflow);
        end
    endtask

    task automatic test_copia();
        for (int i = 0; i < 25; i++) begin
            mem_a[i] = 8'(i * 5 - 60);
            mem_b[i] = -8'sd1;
        end
        mem_a[0] = -8'sd128;
        mem_a[1] = 8'sd127;
        run_op(2'b11, 0, 0, done_at);
        n_cmp++;
        if (wr_data[0] !== -8'sd128 || wr_data[1] !== 8'sd127 || wr_data[12] !== 8'sd0
            || wr_data[24] !== 8'sd60) begin
            n_fail++;
            $display("[TB] FAIL copia_results: C0=%0d C1=%0d C12=%0d C24=%0d, want -128 127 0 60",
                     wr_data[0], wr_data[1], wr_data[12], wr_data[24]);
        end
        n_cmp++;
        if (overflow !== 1'b0) begin
            n_fail++;
            $display("[TB] FAIL copia_overflow: got %b, want 0", overflow);
        end
    endtask

    task automatic test_start_ignored();
        fill_mem(10, 20);
        run_op(2'b00, 10, 0, done_at);
        n_cmp++;
        if (done_at !== 76) begin
            n_fail++;
            $display("[TB] FAIL restart_latency: done at t+%0d, want t+76", done_at);
        end
        n_cmp++;
        if (wr_data[0] !== 8'sd30 || wr_data[24] !== 8'sd30 || wr_data[5] !== 8'sd30) begin
            n_fail++;
            $display("[TB] FAIL restart_op_kept: C0=%0d C5=%0d C24=%0d, want 30",
                     wr_data[0], wr_data[5], wr_data[24]);
        end
        repeat (100) @(negedge clk);
        #1;
        n_cmp++;
        if (wr_n !== 25 || done_cnt !== 1) begin
            n_fail++;
            $display("[TB] FAIL restart_single_run: writes=%0d pulses=%0d, want 25 1", wr_n, done_cnt);
        end
    endtask

    task automatic test_reset_mid();
        fill_mem(10, 20);
        run_op(2'b00, 0, 20, done_at);
        n_cmp++;
        if ({endereco, re_mem, we_mem, dado_c, ocupado, done, overflow} !== 18'd0) begin
            n_fail++;
            $display("[TB] FAIL midreset_outputs: got %b, want all zero",
                     {endereco, re_mem, we_mem, dado_c, ocupado, done, overflow});
        end
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        repeat (30) @(negedge clk);
        #1;
        n_cmp++;
        if (wr_n !== 6 || done_cnt !== 0 || ocupado !== 1'b0) begin
            n_fail++;
            $display("[TB] FAIL midreset_abandon: writes=%0d pulses=%0d ocupado=%b, want 6 0 0",
                     wr_n, done_cnt, ocupado);
        end
        run_op(2'b00, 0, 0, done_at);
        n_cmp++;
        if (done_at !== 76 || wr_n !== 25 || wr_data[24] !== 8'sd30) begin
            n_fail++;
            $display("[TB] FAIL midreset_rerun: done at t+%0d writes=%0d C24=%0d, want 76 25 30",
                     done_at, wr_n, wr_data[24]);
        end
    endtask

    task automatic test_back_to_back();
        fill_mem(10, 20);
        mem_a[0] = -8'sd128;
        mem_b[0] = 8'sd1;
        run_op(2'b01, 0, 0, done_at);
        n_cmp++;
        if (overflow !== 1'b1) begin
            n_fail++;
            $display("[TB] FAIL b2b_first_overflow: got %b, want 1", overflow);
        end
        run_op(2'b00, 0, 0, done_at);
        n_cmp++;
        if (done_at !== 76 || wr_n !== 25) begin
            n_fail++;
            $display("[TB] FAIL b2b_second_run: done at t+%0d writes=%0d, want 76 25", done_at, wr_n);
        end
        n_cmp++;
        if (overflow !== 1'b0 || wr_data[0] !== -8'sd127) begin
            n_fail++;
            $display("[TB] FAIL b2b_overflow_cleared: overflow=%b C0=%0d, want 0 -127",
                     overflow, wr_data[0]);
        end
    endtask

    initial begin
        n_cmp  = 0;
        n_fail = 0;
        test_reset();
        test_soma();
        test_sub_overflow();
        test_oposto();
        test_copia();
        test_start_ignored();
        test_reset_mid();
        test_back_to_back();
        repeat (2) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
